load_store_instructions: RTL and testbench

Load/store execution block for the Mk1 CPU datapath. It computes the effective address `read1 + immediate`, registers it, and accesses a small internal word-addressed data memory. Loads return the addressed word on a registered read-data output; stores write `load_value` into memory. It sits after register-file read and immediate generation, in place of a separate memory stage.

---
 rtl/mk1_pkg.sv | 13 +
 rtl/data_mem.sv | 34 +++
 rtl/load_store_instructions.sv | 52 +++++
 tb/tb_load_store_instructions.sv | 113 +++++++++++
 4 files changed

// File: rtl/mk1_pkg.sv
// Shared Mk1 datapath constants: data width, data-memory depth and word indexing.
package mk1_pkg;
  localparam int DATA_W    = 32;
  localparam int MEM_WORDS = 64;
  localparam int ADDR_LSB  = 2;                  // byte address -> word index shift
  localparam int IDX_W     = $clog2(MEM_WORDS);  // word-index width

  // Word index of a byte address; the low byte-offset bits are dropped (aligned down)
  // and everything above the index is ignored, so addresses wrap every MEM_WORDS words.
  function automatic logic [IDX_W-1:0] word_idx(input logic [DATA_W-1:0] addr);
    return addr[ADDR_LSB +: IDX_W];
  endfunction
endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: synchronous write, write-first read port, async clear.
// The read word is combinational; the caller owns the read-data register.
module data_mem
  import mk1_pkg::*;
#(
  parameter int DW    = DATA_W,
  parameter int WORDS = MEM_WORDS,
  parameter int IW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [IW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [WORDS-1:0][DW-1:0] mem;

  // Store port; reset clears every word and suppresses a write on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Write-first: a store in flight to the read word forwards its data.
  // Read and write share one address, so a store always hits the read word.
  always_comb begin
    rdata = mem[addr];
    if (we) rdata = wdata;
  end
endmodule

// File: rtl/load_store_instructions.sv
// Mk1 load/store execute block: ea = read1 + immediate, registered address,
// single-cycle load/store against the internal data memory.
module load_store_instructions
  import mk1_pkg::*;
#(
  parameter int DATA_W    = mk1_pkg::DATA_W,
  parameter int MEM_WORDS = mk1_pkg::MEM_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] read1,
  input  logic [DATA_W-1:0] immediate,
  input  logic              readEn,
  input  logic              writeEn,
  input  logic [DATA_W-1:0] load_value,
  output logic [DATA_W-1:0] dataAddr_reg,
  output logic [DATA_W-1:0] readData_reg
);
  localparam int IW = $clog2(MEM_WORDS);

  logic [DATA_W-1:0] ea;
  logic [IW-1:0]     idx;
  logic [DATA_W-1:0] rd_word;

  // Modulo-2^DATA_W add; carry dropped. Low byte-offset bits ignored for the word index.
  assign ea  = read1 + immediate;
  assign idx = ea[ADDR_LSB +: IW];

  data_mem #(
    .DW    (DATA_W),
    .WORDS (MEM_WORDS),
    .IW    (IW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (writeEn),
    .addr  (idx),
    .wdata (load_value),
    .rdata (rd_word)
  );

  // Address register tracks ea every cycle; load data only updates on a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dataAddr_reg <= '0;
      readData_reg <= '0;
    end else begin
      dataAddr_reg <= ea;
      if (readEn) readData_reg <= rd_word;
    end
  end
endmodule

// File: tb/tb_load_store_instructions.sv
// Directed self-checking bench for load_store_instructions.
module tb_load_store_instructions;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] read1, immediate, load_value;
  logic        readEn, writeEn;
  logic [31:0] dataAddr_reg, readData_reg;

  int n_chk  = 0;
  int n_fail = 0;

  load_store_instructions #(.DATA_W(32), .MEM_WORDS(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .read1        (read1),
    .immediate    (immediate),
    .readEn       (readEn),
    .writeEn      (writeEn),
    .load_value   (load_value),
    .dataAddr_reg (dataAddr_reg),
    .readData_reg (readData_reg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one request, clock it in, and return 1 time unit after the edge.
  task automatic step(input logic [31:0] r1, input logic [31:0] imm,
                      input logic re, input logic we, input logic [31:0] lv);
    read1 = r1; immediate = imm; readEn = re; writeEn = we; load_value = lv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    read1 = '0; immediate = '0; readEn = 1'b0; writeEn = 1'b0; load_value = '0;

    // Reset held across an edge, with a store attempted (must be dropped).
    step(32'h8, 32'h0, 1'b1, 1'b1, 32'h77);
    chk("rst_addr", dataAddr_reg, 32'h0);
    chk("rst_data", readData_reg, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(32'h8, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("rst_abort_wr", readData_reg, 32'h0);

    // Store then load at 0x5C+4.
    step(32'h5C, 32'h4, 1'b0, 1'b1, 32'h3);
    chk("st_addr", dataAddr_reg, 32'h60);
    chk("st_nold", readData_reg, 32'h0);
    step(32'h5C, 32'h4, 1'b1, 1'b0, 32'h0);
    chk("ld_addr", dataAddr_reg, 32'h60);
    chk("ld_data", readData_reg, 32'h3);

    // Write-first on simultaneous load/store.
    step(32'h10, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF);
    chk("wf_data", readData_reg, 32'hDEADBEEF);
    chk("wf_addr", dataAddr_reg, 32'h10);
    step(32'h0, 32'h10, 1'b1, 1'b0, 32'h0);
    chk("wf_mem", readData_reg, 32'hDEADBEEF);

    // Negative offset and 256-byte wrap: 0x100 aliases word 0.
    step(32'h104, 32'hFFFFFFFC, 1'b0, 1'b1, 32'h0000A5A5);
    chk("neg_addr", dataAddr_reg, 32'h100);
    step(32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("wrap_data", readData_reg, 32'h0000A5A5);
    chk("wrap_addr", dataAddr_reg, 32'h0);

    // Misaligned store lands on the aligned word.
    step(32'h23, 32'h0, 1'b0, 1'b1, 32'h55);
    chk("mis_addr", dataAddr_reg, 32'h23);
    step(32'h20, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("mis_data", readData_reg, 32'h55);

    // Hold: no load for two edges, address keeps tracking.
    step(32'h40, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("hold1_addr", dataAddr_reg, 32'h40);
    chk("hold1_data", readData_reg, 32'h55);
    step(32'h40, 32'h4, 1'b0, 1'b0, 32'h0);
    chk("hold2_addr", dataAddr_reg, 32'h44);
    chk("hold2_data", readData_reg, 32'h55);

    // Carry out of the add is discarded: 0xFFFFFFFF + 1 = 0 -> word 0.
    step(32'hFFFFFFFF, 32'h1, 1'b1, 1'b0, 32'h0);
    chk("carry_addr", dataAddr_reg, 32'h0);
    chk("carry_data", readData_reg, 32'h0000A5A5);

    // Mid-cycle async reset clears outputs immediately, and memory too.
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", dataAddr_reg, 32'h0);
    chk("mid_rst_data", readData_reg, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(32'h60, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("post_rst_ld60", readData_reg, 32'h0);
    chk("post_rst_addr", dataAddr_reg, 32'h60);
    step(32'h10, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("post_rst_ld10", readData_reg, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
